// File: rtl/mem_arbiter.sv
// Two-master (I-cache / D-cache) arbiter in front of the single AXI-bridge cache port.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_addr,
    input  logic        i_strobe,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic [31:0] d_addr,
    input  logic        d_strobe,
    input  logic        d_rw,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_a,
    output logic        mem_access,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_st_data,
    input  logic [31:0] mem_data,
    input  logic        mem_ready
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_i_grants,
    output logic [31:0] stat_d_grants,
    output logic [31:0] stat_i_wait
`endif
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   starve_cnt, starve_nxt;
    logic            access_nxt, write_nxt;
    logic [AW-1:0]   a_nxt;
    logic [1:0]      size_nxt;
    logic [3:0]      sel_nxt;
    logic [DW-1:0]   st_data_nxt;
    logic            force_i;

    // I has been starved long enough: it wins the next arbitration regardless of D
    assign force_i = i_strobe && (starve_cnt == CW'(STARVE_MAX));

    assign i_rdata = mem_data;
    assign d_rdata = mem_data;

    // Next-state, captured request attributes and completion pulses
    always_comb begin
        state_nxt   = state;
        starve_nxt  = starve_cnt;
        access_nxt  = mem_access;
        write_nxt   = mem_write;
        a_nxt       = mem_a;
        size_nxt    = mem_size;
        sel_nxt     = mem_sel;
        st_data_nxt = mem_st_data;
        i_ready     = 1'b0;
        d_ready     = 1'b0;

        case (state)
            IDLE: begin
                if (!i_strobe) begin
                    starve_nxt = '0;
                end
                if (d_strobe && !force_i) begin
                    state_nxt   = GNT_D;
                    access_nxt  = 1'b1;
                    a_nxt       = d_addr;
                    write_nxt   = d_rw;
                    size_nxt    = d_size;
                    sel_nxt     = d_sel;
                    st_data_nxt = d_wdata;
                    if (i_strobe && (starve_cnt != CW'(STARVE_MAX))) begin
                        starve_nxt = starve_cnt + CW'(1);
                    end
                end else if (i_strobe) begin
                    state_nxt  = GNT_I;
                    access_nxt = 1'b1;
                    a_nxt      = i_addr;
                    write_nxt  = 1'b0;
                    size_nxt   = 2'b10;
                    sel_nxt    = 4'b1111;
                    starve_nxt = '0;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    i_ready    = 1'b1;
                    access_nxt = 1'b0;
                    state_nxt  = TURN;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    d_ready    = 1'b1;
                    access_nxt = 1'b0;
                    state_nxt  = TURN;
                end
            end
            TURN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered bridge-side request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            mem_access  <= 1'b0;
            mem_write   <= 1'b0;
            mem_a       <= '0;
            mem_size    <= '0;
            mem_sel     <= '0;
            mem_st_data <= '0;
        end else begin
            state       <= state_nxt;
            starve_cnt  <= starve_nxt;
            mem_access  <= access_nxt;
            mem_write   <= write_nxt;
            mem_a       <= a_nxt;
            mem_size    <= size_nxt;
            mem_sel     <= sel_nxt;
            mem_st_data <= st_data_nxt;
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Wrap-around grant counters and I-side wait cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_i_grants <= '0;
            stat_d_grants <= '0;
            stat_i_wait   <= '0;
        end else begin
            if (state == IDLE && state_nxt == GNT_I) begin
                stat_i_grants <= stat_i_grants + 32'd1;
            end
            if (state == IDLE && state_nxt == GNT_D) begin
                stat_d_grants <= stat_d_grants + 32'd1;
            end
            if (i_strobe && state != GNT_I) begin
                stat_i_wait <= stat_i_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_MAX = 4).
// Stats checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] i_addr;
    logic        i_strobe;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic [31:0] d_addr;
    logic        d_strobe;
    logic        d_rw;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] mem_a;
    logic        mem_access;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic [31:0] mem_data;
    logic        mem_ready;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_i_grants;
    logic [31:0] stat_d_grants;
    logic [31:0] stat_i_wait;
`endif

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .resetn(resetn),
        .i_addr(i_addr), .i_strobe(i_strobe), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_addr(d_addr), .d_strobe(d_strobe), .d_rw(d_rw), .d_size(d_size),
        .d_sel(d_sel), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
        .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
        .mem_data(mem_data), .mem_ready(mem_ready)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
        .stat_i_wait(stat_i_wait)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Complete one transaction for a lone requester: grant, ready, turn
    task automatic txn(input bit is_d);
        if (is_d) d_strobe = 1'b1; else i_strobe = 1'b1;
        tick();
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        d_strobe  = 1'b0;
        i_strobe  = 1'b0;
        tick();
    endtask

    initial begin
        resetn   = 1'b0;
        i_addr   = '0; i_strobe = 1'b0;
        d_addr   = '0; d_strobe = 1'b0; d_rw = 1'b0; d_size = 2'd0;
        d_sel    = '0; d_wdata  = '0;
        mem_data = '0; mem_ready = 1'b0;

        // Reset state
        #12;
        check("rst_access", 32'(mem_access), 32'd0);
        check("rst_a",      mem_a,           32'd0);
        check("rst_st",     mem_st_data,     32'd0);
        check("rst_write",  32'(mem_write),  32'd0);
        check("rst_size",   32'(mem_size),   32'd0);
        check("rst_sel",    32'(mem_sel),    32'd0);
        check("rst_starve", 32'(dut.starve_cnt), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // I alone
        i_addr   = 32'h1FC0_0000;
        i_strobe = 1'b1;
        #1;
        check("i_idle_access", 32'(mem_access), 32'd0);
        tick();
        check("i_access", 32'(mem_access), 32'd1);
        check("i_addr",   mem_a,           32'h1FC0_0000);
        check("i_size",   32'(mem_size),   32'd2);
        check("i_sel",    32'(mem_sel),    32'hF);
        check("i_write",  32'(mem_write),  32'd0);
        check("i_noready", 32'(i_ready),   32'd0);
        tick();
        tick();
        mem_ready = 1'b1;
        mem_data  = 32'h2408_0001;
        #1;
        check("i_ready",     32'(i_ready), 32'd1);
        check("i_rdata",     i_rdata,      32'h2408_0001);
        check("i_d_ready_0", 32'(d_ready), 32'd0);
        tick();
        i_strobe = 1'b0;
        #1;
        check("i_turn_access", 32'(mem_access), 32'd0);
        check("i_turn_ready",  32'(i_ready),    32'd0);
        check("turn_ignore_d", 32'(d_ready),    32'd0);
        mem_ready = 1'b0;
        tick();
        check("i_idle_after", 32'(mem_access), 32'd0);
        tick();

        // Simultaneous: D first, then I after TURN
        i_addr   = 32'h0000_0400; i_strobe = 1'b1;
        d_addr   = 32'h0000_1000; d_strobe = 1'b1; d_rw = 1'b1;
        d_size   = 2'd2; d_sel = 4'b0011; d_wdata = 32'hDEAD_BEEF;
        tick();
        check("sim_d_addr",  mem_a,          32'h0000_1000);
        check("sim_d_write", 32'(mem_write), 32'd1);
        check("sim_d_sel",   32'(mem_sel),   32'h3);
        check("sim_d_st",    mem_st_data,    32'hDEAD_BEEF);
        mem_ready = 1'b1;
        mem_data  = 32'h1234_5678;
        #1;
        check("sim_d_ready", 32'(d_ready), 32'd1);
        check("sim_i_quiet", 32'(i_ready), 32'd0);
        tick();
        mem_ready = 1'b0;
        d_strobe  = 1'b0;
        tick();
        check("sim_idle_access", 32'(mem_access), 32'd0);
        tick();
        check("sim_i_access", 32'(mem_access), 32'd1);
        check("sim_i_addr",   mem_a,           32'h0000_0400);
        check("sim_i_write",  32'(mem_write),  32'd0);
        check("sim_i_sel",    32'(mem_sel),    32'hF);
        mem_ready = 1'b1;
        #1;
        check("sim_i_ready", 32'(i_ready), 32'd1);
        tick();
        mem_ready = 1'b0;
        i_strobe  = 1'b0;
        tick();
        tick();

        // Starvation: D wins 4 times, I forced on the 5th arbitration
        i_addr = 32'h0000_3000; i_strobe = 1'b1;
        d_addr = 32'h0000_2000; d_strobe = 1'b1; d_rw = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("starve_grant", mem_a, (k < 4) ? 32'h0000_2000 : 32'h0000_3000);
            if (k == 3) check("starve_sat", 32'(dut.starve_cnt), 32'd4);
            if (k == 4) check("starve_clr", 32'(dut.starve_cnt), 32'd0);
            mem_ready = 1'b1;
            #1;
            check("starve_i_rdy", 32'(i_ready), (k < 4) ? 32'd0 : 32'd1);
            check("starve_d_rdy", 32'(d_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
            mem_ready = 1'b0;
            tick();
        end
        i_strobe = 1'b0;
        d_strobe = 1'b0;
        tick();

        // Bridge stall for 20 cycles with d_addr changing mid-way
        d_addr = 32'h0000_4000; d_strobe = 1'b1; d_rw = 1'b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            if (k == 10) d_addr = 32'h0000_5000;
            #1;
            check("stall_addr",   mem_a,           32'h0000_4000);
            check("stall_access", 32'(mem_access), 32'd1);
            check("stall_dready", 32'(d_ready),    32'd0);
            tick();
        end
        mem_ready = 1'b1;
        mem_data  = 32'hCAFE_0042;
        #1;
        check("stall_done",  32'(d_ready), 32'd1);
        check("stall_rdata", d_rdata,      32'hCAFE_0042);
        tick();
        mem_ready = 1'b0;
        d_strobe  = 1'b0;
        tick();
        tick();

        // Async reset during GNT_I
        i_addr = 32'h0000_6000; i_strobe = 1'b1;
        tick();
        check("rmid_access_pre", 32'(mem_access), 32'd1);
        resetn = 1'b0;
        #1;
        check("rmid_access", 32'(mem_access), 32'd0);
        mem_ready = 1'b1;
        #1;
        check("rmid_no_iready", 32'(i_ready), 32'd0);
        tick();
        resetn    = 1'b1;
        mem_ready = 1'b0;
        i_strobe  = 1'b0;
        #1;
        check("rmid_state", 32'(dut.state), 32'd0);
        check("rmid_a",     mem_a,          32'd0);
        tick();
        check("rmid_idle_access", 32'(mem_access), 32'd0);

`ifdef MEM_ARB_STATS_EN
        // Stats after 3 I + 2 D transactions since the last reset
        txn(1'b0);
        txn(1'b1);
        txn(1'b0);
        txn(1'b1);
        txn(1'b0);
        check("stat_i_grants", stat_i_grants, 32'd3);
        check("stat_d_grants", stat_d_grants, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
